// File: rtl/seq_table_loader_pkg.sv
// Shared definitions for the sequencer table loader: FSM state encoding,
// load status codes and the sequencer line granularity.
package seq_table_loader_pkg;

   // Load controller states, in the order a successful load visits them
   typedef enum logic [2:0] {
      IDLE,
      WAIT_IDLE,
      START,
      STREAM,
      COMMIT
   } loaderState_t;

   // Result of the most recent load attempt, reported on status_o
   localparam logic [1:0] STAT_OK     = 2'd0;
   localparam logic [1:0] STAT_BADLEN = 2'd1;
   localparam logic [1:0] STAT_ABORT  = 2'd2;

   // The sequencer consumes its table in lines of this many 32-bit words,
   // so every table length must be a whole number of lines
   localparam int SEQ_LINE_WORDS = 4;

endpackage

// File: rtl/seq_table_loader.sv
// Table-load controller for the sequencer. Takes a framed stream of 32-bit
// table words and replays them onto the sequencer's TABLE_START,
// TABLE_DATA/TABLE_WSTB and TABLE_LENGTH/TABLE_LENGTH_WSTB strobes, only
// once the sequencer has gone inactive so a running table is never touched.
module seq_table_loader
   import seq_table_loader_pkg::*;
#(
   parameter int TABLE_WORDS = 1024,
   parameter int LEN_W       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_start_i,
   input  logic [LEN_W-1:0] load_length_i,
   input  logic             abort_i,
   input  logic [31:0]      data_i,
   input  logic             data_valid_i,
   output logic             data_ready_o,
   input  logic             seq_active_i,
   output logic             TABLE_START_o,
   output logic [31:0]      TABLE_DATA_o,
   output logic             TABLE_WSTB_o,
   output logic [LEN_W-1:0] TABLE_LENGTH_o,
   output logic             TABLE_LENGTH_WSTB_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [1:0]       status_o,
   output logic [LEN_W-1:0] words_o
);

   loaderState_t     r_state;
   logic [LEN_W-1:0] r_length;
   logic [LEN_W-1:0] r_words;
   logic [LEN_W-1:0] r_tableLength;
   logic [31:0]      r_tableData;
   logic             r_tableStart;
   logic             r_tableWstb;
   logic             r_lengthWstb;
   logic             r_busy;
   logic             r_done;
   logic [1:0]       r_status;

   logic             w_ready;
   logic             w_accept;

   // A length is loadable when it is a nonzero whole number of sequencer
   // lines that fits in the table. Widened to 32 bits so the comparison
   // against TABLE_WORDS never truncates.
   function automatic logic lengthIsValid(input logic [LEN_W-1:0] len);
      logic [31:0] lenWide;
      lenWide = 32'(len);
      return (lenWide != 32'd0) &&
             ((lenWide % 32'(SEQ_LINE_WORDS)) == 32'd0) &&
             (lenWide <= 32'(TABLE_WORDS));
   endfunction

   // Words are only taken while streaming and short of the latched length;
   // an abort in the same cycle refuses the word so it is never half-loaded.
   always_comb begin
      w_ready  = (r_state == STREAM) && (r_words < r_length) && !abort_i;
      w_accept = w_ready && data_valid_i;
   end

   // Main controller: one registered FSM that also produces every strobe.
   // Strobes default low each cycle and are raised on the transition that
   // calls for them, so each is exactly one cycle wide. An abort in any busy
   // state overrides whatever the state case decided this cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state       <= IDLE;
         r_length      <= '0;
         r_words       <= '0;
         r_tableLength <= '0;
         r_tableData   <= '0;
         r_tableStart  <= 1'b0;
         r_tableWstb   <= 1'b0;
         r_lengthWstb  <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_status      <= STAT_OK;
      end else begin
         r_tableStart <= 1'b0;
         r_tableWstb  <= 1'b0;
         r_lengthWstb <= 1'b0;
         r_done       <= 1'b0;

         if (w_accept) begin
            r_tableData <= data_i;
            r_tableWstb <= 1'b1;
            r_words     <= r_words + LEN_W'(1);
         end

         case (r_state)
            IDLE: begin
               if (load_start_i) begin
                  r_length <= load_length_i;
                  r_words  <= '0;
                  r_status <= STAT_OK;
                  if (lengthIsValid(load_length_i)) begin
                     r_state <= WAIT_IDLE;
                     r_busy  <= 1'b1;
                  end else begin
                     r_status <= STAT_BADLEN;
                     r_done   <= 1'b1;
                  end
               end
            end
            WAIT_IDLE: begin
               if (!seq_active_i) begin
                  r_state      <= START;
                  r_tableStart <= 1'b1;
               end
            end
            START: begin
               r_state <= STREAM;
            end
            STREAM: begin
               if (r_words == r_length) begin
                  r_state       <= COMMIT;
                  r_tableLength <= r_length;
                  r_lengthWstb  <= 1'b1;
                  r_done        <= 1'b1;
                  r_status      <= STAT_OK;
               end
            end
            COMMIT: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         if (abort_i && (r_state != IDLE)) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_status     <= STAT_ABORT;
            r_done       <= 1'b1;
            r_tableStart <= 1'b0;
            r_lengthWstb <= 1'b0;
         end
      end
   end

   assign data_ready_o        = w_ready;
   assign TABLE_START_o       = r_tableStart;
   assign TABLE_DATA_o        = r_tableData;
   assign TABLE_WSTB_o        = r_tableWstb;
   assign TABLE_LENGTH_o      = r_tableLength;
   assign TABLE_LENGTH_WSTB_o = r_lengthWstb;
   assign busy_o              = r_busy;
   assign done_o              = r_done;
   assign status_o            = r_status;
   assign words_o             = r_words;

endmodule

// File: tb/tb_seq_table_loader.sv
// Self-checking bench for seq_table_loader: directed sequences for the
// multi-cycle corners, a table of length-check vectors, and randomized loads
// checked against a transaction-level reference model.
module tb_seq_table_loader;
   import seq_table_loader_pkg::*;

   localparam int TABLE_WORDS = 1024;
   localparam int LEN_W       = 16;

   logic             clk = 1'b0;
   logic             reset_i = 1'b0;
   logic             load_start_i = 1'b0;
   logic [LEN_W-1:0] load_length_i = '0;
   logic             abort_i = 1'b0;
   logic [31:0]      data_i = '0;
   logic             data_valid_i = 1'b0;
   logic             data_ready_o;
   logic             seq_active_i = 1'b0;
   logic             TABLE_START_o;
   logic [31:0]      TABLE_DATA_o;
   logic             TABLE_WSTB_o;
   logic [LEN_W-1:0] TABLE_LENGTH_o;
   logic             TABLE_LENGTH_WSTB_o;
   logic             busy_o;
   logic             done_o;
   logic [1:0]       status_o;
   logic [LEN_W-1:0] words_o;

   seq_table_loader #(.TABLE_WORDS(TABLE_WORDS), .LEN_W(LEN_W)) dut (
      .clk_i               (clk),
      .reset_i             (reset_i),
      .load_start_i        (load_start_i),
      .load_length_i       (load_length_i),
      .abort_i             (abort_i),
      .data_i              (data_i),
      .data_valid_i        (data_valid_i),
      .data_ready_o        (data_ready_o),
      .seq_active_i        (seq_active_i),
      .TABLE_START_o       (TABLE_START_o),
      .TABLE_DATA_o        (TABLE_DATA_o),
      .TABLE_WSTB_o        (TABLE_WSTB_o),
      .TABLE_LENGTH_o      (TABLE_LENGTH_o),
      .TABLE_LENGTH_WSTB_o (TABLE_LENGTH_WSTB_o),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .status_o            (status_o),
      .words_o             (words_o)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Cycle number, advanced on every rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor: logs every strobe seen on the sequencer side, sampled
   // on the falling edge when registered outputs are stable
   logic [31:0]      wrQ[$];
   int               startCnt = 0, lenCnt = 0, doneCnt = 0;
   int               startCyc = -1, lenCyc = -1, doneCyc = -1;
   always @(negedge clk) begin
      if (TABLE_WSTB_o) wrQ.push_back(TABLE_DATA_o);
      if (TABLE_START_o) begin startCnt++; startCyc = cyc; end
      if (TABLE_LENGTH_WSTB_o) begin lenCnt++; lenCyc = cyc; end
      if (done_o) begin doneCnt++; doneCyc = cyc; end
   end

   int               assertCount = 0;
   int               failCount = 0;
   string            curTest = "init";

   logic [31:0]      txQ[$];
   int               baseStart, baseLen, baseDone, baseWr;
   int               tStart, wCyc, lastCyc, abortCyc, firstReady, accepted, earlyReady;

   typedef struct {
      int   len;
      logic expBad;
   } lenVec_t;
   lenVec_t lenTable[9];

   // Watchdog so a stuck handshake can never hang the run
   initial begin
      #900000;
      $display("[TB] FAIL %s.watchdog: got timeout, expected end of test", curTest);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", curTest, name, actual, expected);
      end
   endtask

   // Step to just after the next falling edge: monitor has sampled, inputs
   // changed here are settled well before the following rising edge
   task automatic nextCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic snapshot();
      baseStart = startCnt;
      baseLen   = lenCnt;
      baseDone  = doneCnt;
      baseWr    = wrQ.size();
   endtask

   // Reference rule for a loadable length
   function automatic bit refLengthOk(input int len);
      return (len > 0) && (len % 4 == 0) && (len <= TABLE_WORDS);
   endfunction

   task automatic fillTx(input int len, input bit randomData, input logic [31:0] base);
      txQ.delete();
      for (int i = 0; i < len; i++)
         txQ.push_back(randomData ? $urandom : base + 32'(i));
   endtask

   task automatic checkAllZero();
      checkOutput("rstStart", TABLE_START_o, 0);
      checkOutput("rstData", TABLE_DATA_o, 0);
      checkOutput("rstWstb", TABLE_WSTB_o, 0);
      checkOutput("rstLength", TABLE_LENGTH_o, 0);
      checkOutput("rstLenWstb", TABLE_LENGTH_WSTB_o, 0);
      checkOutput("rstBusy", busy_o, 0);
      checkOutput("rstDone", done_o, 0);
      checkOutput("rstStatus", status_o, 0);
      checkOutput("rstWords", words_o, 0);
      checkOutput("rstReady", data_ready_o, 0);
   endtask

   // Runs one load attempt. gapMode: 0 back-to-back, 1 valid every other
   // cycle, 2 random valid. abortAfter >= 1 aborts once that many words are
   // in, with a valid word offered in the abort cycle; -1 never aborts.
   task automatic applyStimulus(input int len, input int seqBusy, input int gapMode, input int abortAfter);
      int budget;
      bit v;
      snapshot();
      accepted = 0; firstReady = -1; lastCyc = -1; abortCyc = -1; earlyReady = 0;
      seq_active_i  = (seqBusy > 0);
      load_start_i  = 1'b1;
      load_length_i = LEN_W'(len);
      tStart = cyc;
      nextCycle();
      load_start_i  = 1'b0;
      load_length_i = LEN_W'($urandom);
      if (!refLengthOk(len)) begin
         checkOutput("badLenDoneT1", done_o, 1);
         checkOutput("badLenStatusT1", status_o, STAT_BADLEN);
         checkOutput("badLenBusyT1", busy_o, 0);
         nextCycle();
         nextCycle();
         return;
      end
      checkOutput("busyT1", busy_o, 1);
      for (int i = 0; i < seqBusy; i++) begin
         if (data_ready_o) earlyReady++;
         nextCycle();
      end
      seq_active_i = 1'b0;
      wCyc = cyc;
      budget = 8 * len + 64;
      while (accepted < len) begin
         if (budget == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s.streamTimeout: got %0d words, expected %0d", curTest, accepted, len);
            data_valid_i = 1'b0;
            abort_i = 1'b1;
            nextCycle();
            abort_i = 1'b0;
            return;
         end
         budget--;
         if (gapMode == 1)      v = (cyc % 2 == 0);
         else if (gapMode == 2) v = 1'($urandom_range(0, 1));
         else                   v = 1'b1;
         if (gapMode == 2 && cyc > wCyc + 1) seq_active_i = 1'($urandom_range(0, 1));
         if (accepted == abortAfter) begin
            abort_i      = 1'b1;
            data_valid_i = 1'b1;
            data_i       = txQ[accepted];
            #1;
            checkOutput("readyInAbortCycle", data_ready_o, 0);
            abortCyc = cyc;
            nextCycle();
            abort_i      = 1'b0;
            data_valid_i = 1'b0;
            seq_active_i = 1'b0;
            checkOutput("abortDoneA1", done_o, 1);
            checkOutput("abortBusyA1", busy_o, 0);
            checkOutput("abortStatusA1", status_o, STAT_ABORT);
            nextCycle();
            return;
         end
         data_valid_i = v;
         data_i       = v ? txQ[accepted] : $urandom;
         #1;
         if (data_ready_o && firstReady < 0) firstReady = cyc;
         if (v && data_ready_o) begin
            accepted++;
            lastCyc = cyc;
         end
         nextCycle();
      end
      data_valid_i = 1'b0;
      seq_active_i = 1'b0;
      nextCycle();
      checkOutput("lenWstbL2", TABLE_LENGTH_WSTB_o, 1);
      checkOutput("doneL2", done_o, 1);
      checkOutput("busyL2", busy_o, 1);
      nextCycle();
      checkOutput("busyLowL3", busy_o, 0);
   endtask

   // Transaction-level expectations for the load just run
   task automatic checkLoad(input int len, input int abortAfter);
      bit ok;
      int expStatus, expWords, nWr;
      ok        = refLengthOk(len);
      expStatus = !ok ? 1 : (abortAfter >= 0 ? 2 : 0);
      expWords  = !ok ? 0 : (abortAfter >= 0 ? abortAfter : len);
      nWr       = wrQ.size() - baseWr;
      checkOutput("status", status_o, expStatus);
      checkOutput("words", words_o, expWords);
      checkOutput("writeCount", nWr, expWords);
      for (int i = 0; i < expWords && i < nWr; i++)
         checkOutput($sformatf("writeData[%0d]", i), wrQ[baseWr + i], txQ[i]);
      checkOutput("startCount", startCnt - baseStart, ok ? 1 : 0);
      checkOutput("lenWstbCount", lenCnt - baseLen, (expStatus == 0) ? 1 : 0);
      checkOutput("doneCount", doneCnt - baseDone, 1);
      if (ok) begin
         checkOutput("earlyReady", earlyReady, 0);
         checkOutput("startTiming", startCyc, wCyc + 1);
         checkOutput("firstReady", firstReady, wCyc + 2);
      end
      if (!ok)
         checkOutput("doneTiming", doneCyc, tStart + 1);
      else if (abortAfter >= 0)
         checkOutput("doneTiming", doneCyc, abortCyc + 1);
      else begin
         checkOutput("doneTiming", doneCyc, lastCyc + 2);
         checkOutput("lenTiming", lenCyc, lastCyc + 2);
         checkOutput("lenValue", TABLE_LENGTH_o, len);
      end
   endtask

   initial begin
      lenTable[0] = '{0,      1'b1};
      lenTable[1] = '{6,      1'b1};
      lenTable[2] = '{1028,   1'b1};
      lenTable[3] = '{3,      1'b1};
      lenTable[4] = '{65535,  1'b1};
      lenTable[5] = '{65532,  1'b1};
      lenTable[6] = '{4,      1'b0};
      lenTable[7] = '{1024,   1'b0};
      lenTable[8] = '{1020,   1'b0};

      // Power-on reset
      curTest = "reset";
      reset_i = 1'b1;
      repeat (3) nextCycle();
      checkAllZero();
      reset_i = 1'b0;
      nextCycle();

      // Idle sequencer, 8 words 0x1..0x8 back-to-back
      curTest = "basic8";
      fillTx(8, 1'b0, 32'h1);
      applyStimulus(8, 0, 0, -1);
      checkLoad(8, -1);
      checkOutput("startAtT2", startCyc, tStart + 2);

      // Sequencer busy for 20 cycles after the request
      curTest = "seqActive20";
      fillTx(8, 1'b1, 32'h0);
      applyStimulus(8, 20, 0, -1);
      checkLoad(8, -1);

      // Length-check vectors, sequencer held active so valid ones park
      for (int i = 0; i < 9; i++) begin
         curTest = $sformatf("lenTable[%0d]", i);
         snapshot();
         seq_active_i  = 1'b1;
         load_start_i  = 1'b1;
         load_length_i = LEN_W'(lenTable[i].len);
         nextCycle();
         load_start_i  = 1'b0;
         checkOutput("doneT1", done_o, lenTable[i].expBad);
         checkOutput("statusT1", status_o, lenTable[i].expBad ? STAT_BADLEN : STAT_OK);
         checkOutput("busyT1", busy_o, !lenTable[i].expBad);
         if (lenTable[i].expBad) begin
            abort_i = 1'b1;
            nextCycle();
            abort_i = 1'b0;
            nextCycle();
            checkOutput("idleAbortDone", doneCnt - baseDone, 1);
            checkOutput("idleAbortStatus", status_o, STAT_BADLEN);
         end else begin
            load_start_i  = 1'b1;
            load_length_i = LEN_W'(6);
            nextCycle();
            load_start_i  = 1'b0;
            nextCycle();
            checkOutput("busyStartIgnored", status_o, STAT_OK);
            checkOutput("busyStartNoDone", doneCnt - baseDone, 0);
            abort_i = 1'b1;
            nextCycle();
            abort_i = 1'b0;
            checkOutput("waitAbortDone", done_o, 1);
            checkOutput("waitAbortStatus", status_o, STAT_ABORT);
            checkOutput("waitAbortBusy", busy_o, 0);
         end
         seq_active_i = 1'b0;
         nextCycle();
         checkOutput("noStartStrobe", startCnt - baseStart, 0);
         checkOutput("noLenStrobe", lenCnt - baseLen, 0);
         checkOutput("noWrites", wrQ.size() - baseWr, 0);
      end

      // Length 12, valid toggling every other cycle
      curTest = "toggle12";
      fillTx(12, 1'b0, 32'h100);
      applyStimulus(12, 0, 1, -1);
      checkLoad(12, -1);

      // Abort after 5 of 8 words with a word offered in the abort cycle
      curTest = "abort5of8";
      fillTx(8, 1'b1, 32'h0);
      applyStimulus(8, 0, 0, 5);
      checkLoad(8, 5);

      // Reset in the middle of streaming, then a fresh length-4 load
      curTest = "resetMidStream";
      snapshot();
      load_start_i  = 1'b1;
      load_length_i = LEN_W'(8);
      nextCycle();
      load_start_i  = 1'b0;
      nextCycle();
      nextCycle();
      for (int i = 0; i < 3; i++) begin
         data_valid_i = 1'b1;
         data_i       = 32'hA0 + 32'(i);
         nextCycle();
      end
      reset_i = 1'b1;
      nextCycle();
      data_valid_i = 1'b0;
      checkAllZero();
      reset_i = 1'b0;
      nextCycle();
      nextCycle();
      checkOutput("noLenWstbAfterReset", lenCnt - baseLen, 0);
      curTest = "afterReset4";
      fillTx(4, 1'b1, 32'h0);
      applyStimulus(4, 0, 0, -1);
      checkLoad(4, -1);

      // Randomized loads against the reference model
      for (int n = 0; n < 40; n++) begin
         int len, seqBusy, gap, ab;
         curTest = $sformatf("rand[%0d]", n);
         if ($urandom_range(0, 5) == 0) len = int'($urandom_range(0, 65535));
         else                           len = 4 * int'($urandom_range(1, 8));
         seqBusy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
         gap     = int'($urandom_range(0, 2));
         ab      = (refLengthOk(len) && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
         fillTx(refLengthOk(len) ? len : 0, 1'b1, 32'h0);
         applyStimulus(len, seqBusy, gap, ab);
         checkLoad(len, ab);
         repeat ($urandom_range(0, 3)) nextCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/seq_table_loader.md
# seq_table_loader

Table-load controller for the sequencer block. It accepts a framed stream of 32-bit table words from the DMA/FIFO side and drives the sequencer's TABLE_START, TABLE_DATA/TABLE_WSTB and TABLE_LENGTH/TABLE_LENGTH_WSTB register strobes in the required order. A load is only started once the sequencer reports inactive, so the table is never rewritten mid-run. It sits between the register/DMA interface and the sequencer, replacing direct software pokes of the table registers.

## Interface
- TABLE_WORDS, 1024, maximum table depth in 32-bit words (multiple of 4)
- LEN_W, 16, width of length and word counters

- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- load_start_i  in  1  one-cycle request to begin a load
- load_length_i  in  LEN_W  number of words to load, sampled with load_start_i
- abort_i  in  1  cancel the current load
- data_i  in  32  table word
- data_valid_i  in  1  data_i valid
- data_ready_o  out  1  word accepted when data_valid_i & data_ready_o
- seq_active_i  in  1  sequencer active_o
- TABLE_START_o  out  1  one-cycle table reset strobe to the sequencer
- TABLE_DATA_o  out  32  word to sequencer
- TABLE_WSTB_o  out  1  TABLE_DATA_o write strobe
- TABLE_LENGTH_o  out  LEN_W  committed length
- TABLE_LENGTH_WSTB_o  out  1  length commit strobe
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse at the end of any load attempt
- status_o  out  2  0 = OK, 1 = bad length, 2 = aborted; held until the next load_start_i
- words_o  out  LEN_W  words accepted in the current or last load

## Operation
- States: IDLE, WAIT_IDLE, START, STREAM, COMMIT.
- IDLE: load_start_i latches load_length_i and clears words_o and status_o.
  - Length is valid if it is nonzero, a multiple of 4 and no greater than TABLE_WORDS. A valid length moves to WAIT_IDLE.
  - An invalid length sets status_o=1, pulses done_o and stays in IDLE. No TABLE_* strobe is issued.
- WAIT_IDLE: waits while seq_active_i=1. When seq_active_i=0, moves to START.
- START: TABLE_START_o pulses for one cycle, then moves to STREAM.
- STREAM: data_ready_o=1 while words_o < latched length.
  - Each accepted word increments words_o and drives TABLE_DATA_o with TABLE_WSTB_o=1 on the following cycle.
  - After the last word is accepted, moves to COMMIT.
- COMMIT: TABLE_LENGTH_o is set to the latched length with TABLE_LENGTH_WSTB_o=1 for one cycle. done_o pulses, status_o=0, then returns to IDLE.
- abort_i in any non-IDLE state:
  - Returns to IDLE, sets status_o=2 and pulses done_o. TABLE_LENGTH_WSTB_o is never issued.
  - A word offered in the abort cycle is not accepted (data_ready_o=0 that cycle).
- load_start_i while busy_o=1 is ignored. abort_i in IDLE is ignored.
- seq_active_i is examined only in WAIT_IDLE.
- words_o saturates at the latched length. Arithmetic is unsigned LEN_W-bit.

## Timing
- Reset: every output is 0 and the state is IDLE. Reset mid-load discards the load without issuing TABLE_LENGTH_WSTB_o.
- All outputs are registered. data_ready_o is combinational from state, words_o and abort_i.
- load_start_i at cycle T with a valid length: busy_o=1 from T+1.
- Let W be the first WAIT_IDLE cycle with seq_active_i=0 (W=T+1 if the sequencer is idle). Then TABLE_START_o is high at W+1 and data_ready_o is high from W+2.
- A word accepted at cycle N appears on TABLE_DATA_o with TABLE_WSTB_o at N+1. Full throughput is one word per cycle.
- Last word accepted at cycle L: TABLE_LENGTH_WSTB_o and done_o at L+2, busy_o low from L+3.
- Bad length at T: done_o and status_o=1 at T+1. busy_o stays 0.
- Abort asserted at A: done_o at A+1, busy_o low from A+1.

## Structure
- A shared package holds:
  - the state enum;
  - the status codes STAT_OK, STAT_BADLEN, STAT_ABORT;
  - the SEQ_LINE_WORDS=4 constant.
- Single module, no sub-module. The length check is a local function.

## Test plan
- Idle sequencer, length 8, eight words 0x1..0x8 streamed back-to-back:
  - TABLE_START_o at T+2;
  - eight TABLE_WSTB_o pulses carrying 0x1..0x8 in order;
  - TABLE_LENGTH_o=8 with TABLE_LENGTH_WSTB_o at L+2;
  - status_o=0, words_o=8.
- seq_active_i held high for 20 cycles after load_start_i: no TABLE_START_o or data_ready_o until 1 cycle after seq_active_i falls, then a normal load.
- Lengths 0, 6 and TABLE_WORDS+4 each give status_o=1 and done_o at T+1, with zero TABLE_* strobes. Length TABLE_WORDS is accepted.
- Length 12 with data_valid_i toggling every other cycle: exactly 12 TABLE_WSTB_o pulses, matching data order, and no extra accepts.
- abort_i after 5 of 8 words, with a valid word offered in the same cycle:
  - words_o=5, status_o=2, done_o next cycle;
  - no TABLE_LENGTH_WSTB_o.
- reset_i mid-STREAM, then a new length-4 load: all outputs 0 after reset, and the second load completes with status_o=0.
